// File: rtl/dpram_dma_engine_pkg.sv
// dpram_dma_pkg: shared types for the dual-port RAM DMA engine.
//   state_e : controller states
//   mode_e  : job type (block copy or block fill)
//   dir_e   : pointer walk direction for a copy
package dpram_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

    typedef enum logic {
        MODE_COPY = 1'b0,
        MODE_FILL = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_ASC  = 1'b0,
        DIR_DESC = 1'b1
    } dir_e;

endpackage

// File: rtl/dpram_dma_engine_if.sv
// dpram_dma_engine_if: one port of a dual-port RAM.
//   en, we, addr, wdata : driven by the initiator (master)
//   rdata               : driven by the RAM (slave), combinational on addr
interface dpram_dma_engine_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) ();
    logic                  en;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output en, we, addr, wdata, input rdata);
    modport slave  (input en, we, addr, wdata, output rdata);
endinterface

// File: rtl/dpram_dma_engine.sv
// dpram_dma_engine: block copy (read port A, write port B) or block fill
// (port B only) at one word per cycle. Overlapping copies with the
// destination above the source walk downwards so no word is overwritten
// before it has been read.
//   clk, rst_n            : clock, synchronous active-low reset
//   start, mode           : job request (sampled in IDLE), 0 copy / 1 fill
//   src_addr, dst_addr    : base addresses
//   len                   : word count, legal 0..DEPTH
//   fill_data             : fill pattern
//   abort                 : cancel a running job
//   busy, done            : job in progress, one-cycle completion pulse
//   err, aborted          : qualifiers valid with done
//   port_a, port_b        : RAM ports (master side)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing one read (or fill slot) per cycle, writing the previous one
// DRAIN | last write in flight, no further reads
// FIN   | done pulse with err/aborted, then back to IDLE
module dpram_dma_engine
    import dpram_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  aborted,
    dpram_dma_engine_if.master    port_a,
    dpram_dma_engine_if.master    port_b
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    mode_e                 mode_q, mode_d;
    dir_e                  dir_q, dir_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  aborted_q, aborted_d;
    logic                  a_en_q, a_en_d;
    logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d;
    // valid_q/data_q form the single pipeline stage between read and write;
    // they drive port B directly.
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] b_addr_q, b_addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    mode_e                 mode_in;
    logic                  start_desc;
    logic [ADDR_WIDTH-1:0] len_lo;
    logic                  unused_b_rdata;

    assign mode_in = mode_e'(mode);
    assign len_lo  = len[ADDR_WIDTH-1:0];
    // The upper bound is evaluated one bit wider so it does not wrap; overlaps
    // that wrap past the top of memory therefore fall back to ascending.
    assign start_desc = (mode_in == MODE_COPY) && (dst_addr > src_addr) &&
                        ({1'b0, dst_addr} < ({1'b0, src_addr} + len));
    assign unused_b_rdata = ^port_b.rdata;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        dir_d     = dir_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        fill_d    = fill_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        aborted_d = 1'b0;
        a_en_d    = 1'b0;
        a_addr_d  = '0;
        valid_d   = 1'b0;
        b_addr_d  = '0;
        data_d    = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len > DEPTH_W) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (len == '0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                        mode_d  = mode_in;
                        fill_d  = fill_data;
                        cnt_d   = len;
                        dir_d   = start_desc ? DIR_DESC : DIR_ASC;
                        // len == DEPTH makes len_lo zero, so base-1 wraps to
                        // the correct last word.
                        rd_ptr_d = start_desc ? src_addr + len_lo - ONE_A : src_addr;
                        wr_ptr_d = start_desc ? dst_addr + len_lo - ONE_A : dst_addr;
                        a_en_d   = (mode_in == MODE_COPY);
                        a_addr_d = (mode_in == MODE_COPY) ? rd_ptr_d : '0;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d   = FIN;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else begin
                    valid_d  = 1'b1;
                    b_addr_d = wr_ptr_q;
                    data_d   = (mode_q == MODE_FILL) ? fill_q : port_a.rdata;
                    wr_ptr_d = (dir_q == DIR_DESC) ? wr_ptr_q - ONE_A : wr_ptr_q + ONE_A;
                    if (cnt_q == ONE_C) begin
                        state_d = DRAIN;
                    end else begin
                        cnt_d    = cnt_q - ONE_C;
                        rd_ptr_d = (dir_q == DIR_DESC) ? rd_ptr_q - ONE_A : rd_ptr_q + ONE_A;
                        a_en_d   = (mode_q == MODE_COPY);
                        a_addr_d = (mode_q == MODE_COPY) ? rd_ptr_d : '0;
                    end
                end
            end
            DRAIN: begin
                state_d   = FIN;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                aborted_d = abort;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode_q    <= MODE_COPY;
            dir_q     <= DIR_ASC;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            fill_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
            a_en_q    <= 1'b0;
            a_addr_q  <= '0;
            valid_q   <= 1'b0;
            b_addr_q  <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            dir_q     <= dir_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            fill_q    <= fill_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            aborted_q <= aborted_d;
            a_en_q    <= a_en_d;
            a_addr_q  <= a_addr_d;
            valid_q   <= valid_d;
            b_addr_q  <= b_addr_d;
            data_q    <= data_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign aborted = aborted_q;

    assign port_a.en    = a_en_q;
    assign port_a.we    = 1'b0;
    assign port_a.addr  = a_addr_q;
    assign port_a.wdata = '0;

    assign port_b.en    = valid_q;
    assign port_b.we    = valid_q;
    assign port_b.addr  = b_addr_q;
    assign port_b.wdata = data_q;

endmodule

// File: doc/dpram_dma_engine.md
Name: dpram_dma_engine

Overview:
- Initiator-side block for the dual-port RAM port interface: drives the `en`/`we`/`addr`/`wdata` signals on both ports and consumes `rdata`.
- Performs block copy (reads on port A, writes on port B) or block fill (port B only) at one word per cycle.
- Handles overlapping copies by choosing the copy direction.
- Sits between the CPU control/MMIO logic and a dual-port RAM instance. Frees the CPU from memmove/memset loops.

Parameters:
- ADDR_WIDTH, 8, RAM address width.
- DATA_WIDTH, 32, RAM word width.
- DEPTH, 1 << ADDR_WIDTH, RAM words. Legal lengths are 0..DEPTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  job request, sampled only while idle.
- mode  in  1  0 = copy, 1 = fill.
- src_addr  in  ADDR_WIDTH  copy source base.
- dst_addr  in  ADDR_WIDTH  destination base.
- len  in  ADDR_WIDTH+1  word count.
- fill_data  in  DATA_WIDTH  fill pattern.
- abort  in  1  cancel the running job.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: len > DEPTH.
- aborted  out  1  valid with done: job was cancelled.
- a_en, a_we, a_addr, a_wdata  out  1/1/ADDR_WIDTH/DATA_WIDTH  port A drive. Bundled onto dual_port_ram_port_if at the parent.
- a_rdata  in  DATA_WIDTH  port A read data. The RAM read is combinational on a_addr.
- b_en, b_we, b_addr, b_wdata  out  1/1/ADDR_WIDTH/DATA_WIDTH  port B drive.
- b_rdata  in  DATA_WIDTH  unused.

Behaviour:
- Reset (rst_n low at an edge): state IDLE; all outputs 0; pipeline valid flag cleared. Reset mid-job stops all access on the next cycle. Partial writes remain in RAM.
- a_we is tied 0. Port A never writes.
- States are IDLE, RUN, DRAIN, FIN.
- IDLE, start sampled high in cycle T:
  - If len > DEPTH: go to FIN with err=1; no access.
  - If len == 0: go to FIN with err=0; no access.
  - Otherwise: latch parameters, compute direction, go to RUN. busy=1 from T+1.
- Direction: descending iff mode == copy and dst_addr > src_addr and dst_addr < src_addr + len.
  - The sum is computed ADDR_WIDTH+1 wide, unwrapped.
  - Otherwise ascending.
  - Overlap that wraps past DEPTH-1 is unsupported. It copies ascending, with no error flagged.
- RUN, copy: each cycle, a_en=1 and a_addr=rd_ptr; a_rdata is captured into data_q with valid_q=1.
  - Next cycle: b_en=b_we=1, b_addr=wr_ptr, b_wdata=data_q.
  - Pointers step ±1 and wrap modulo DEPTH.
  - Descending start pointers are base+len-1.
- RUN, fill: same timing. data_q is loaded from fill_data and port A stays idle.
- First write occurs at T+2; last write at T+len+1. Throughput is 1 word per cycle.
- After the final read issue, go to DRAIN (final write), then FIN.
- FIN: done=1 for exactly one cycle with err/aborted valid, busy=0, then IDLE.
  - Normal job: done at T+len+2.
  - Empty or error job: done at T+1.
- abort high in cycle C during RUN/DRAIN:
  - Any write or read issued in C completes.
  - No memory access occurs from C+1.
  - The pending data_q is discarded.
  - Go to FIN with aborted=1; done at C+1.
  - abort while IDLE or FIN is ignored.
- start while busy is ignored.
- start and abort together in IDLE: start wins; abort is ignored.
- Hazard-free by construction: in descending copies, no address is written before it is read.
- A same-cycle read/write to one address returns the old word.
- Outputs en/we/addr/wdata are registered; each is 0 whenever its port is not accessing.

Decomposition:
- Package dpram_dma_pkg holds:
  - the state enum (IDLE/RUN/DRAIN/FIN);
  - the mode enum (MODE_COPY/MODE_FILL);
  - the direction enum.
- No sub-module is required. Pointer and counter logic stays inline.

Test Plan:
- Copy, mem[0x10..0x13]=A0..A3, src=0x10, dst=0x40, len=4, start at T -> port B writes 0x40..0x43 = A0..A3 at T+2..T+5; done at T+6; busy high T+1..T+5.
- Overlapping copy, mem[0x20..0x25]=1..6, src=0x20, dst=0x22, len=4 -> write order 0x25, 0x24, 0x23, 0x22; final mem[0x22..0x25]=1,2,3,4; mem[0x20..0x21]=1,2.
- Fill with wrap, dst=0xFE, len=4, fill=0xDEADBEEF -> writes at 0xFE, 0xFF, 0x00, 0x01; a_en never asserted; done at T+6.
- len=0, then len=257 (ADDR_WIDTH=8) -> each gives done at T+1, no en on either port; err=0 then err=1; busy never high.
- Abort: copy len=8, abort high at T+4 -> exactly 3 writes (T+2..T+4); no access from T+5; done and aborted=1 at T+5.
- Reset: rst_n low at T+3 during an 8-word copy -> all outputs 0 from T+4; a new start after release runs normally.
